// File: rtl/count_blinker_if.sv
// Handshake bundle between a count source and the blinker: start/value in,
// led/busy/done back.
interface count_blinker_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] value;
   logic             led;
   logic             busy;
   logic             done;

   modport master (
      output start, value,
      input  led, busy, done
   );

   modport slave (
      input  start, value,
      output led, busy, done
   );
endinterface

// File: rtl/count_blinker.sv
// Serialises a captured count into N LED pulses followed by a quiet gap,
// then emits a one-cycle done strobe. All outputs are registered.
module count_blinker #(
   parameter int WIDTH     = 8,
   parameter int ON_TICKS  = 250,
   parameter int OFF_TICKS = 250,
   parameter int GAP_TICKS = 1000,
   parameter int TICK_W    = 16
) (
   input  logic            clk,
   input  logic            rst,
   count_blinker_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_OFF,
      S_GAP
   } state_t;

   // Tick counter counts down to zero, so each phase loads its length minus one.
   localparam logic [TICK_W-1:0] ON_LOAD  = TICK_W'(ON_TICKS - 1);
   localparam logic [TICK_W-1:0] OFF_LOAD = TICK_W'(OFF_TICKS - 1);
   localparam logic [TICK_W-1:0] GAP_LOAD = TICK_W'(GAP_TICKS - 1);

   state_t             state_q, state_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [WIDTH-1:0]   remaining_q, remaining_d;
   logic [WIDTH-1:0]   remaining_dec;
   logic               led_q, led_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               tick_zero;

   assign tick_zero     = (tick_q == '0);
   assign remaining_dec = remaining_q - WIDTH'(1);

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      remaining_d = remaining_q;
      led_d       = led_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            led_d  = 1'b0;
            busy_d = 1'b0;
            if (bus.start) begin
               remaining_d = bus.value;
               if (bus.value != '0) begin
                  state_d = S_ON;
                  tick_d  = ON_LOAD;
                  led_d   = 1'b1;
                  busy_d  = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         S_ON: begin
            if (tick_zero) begin
               // Decrement only happens here, where remaining is known to be >= 1.
               remaining_d = remaining_dec;
               led_d       = 1'b0;
               if (remaining_dec != '0) begin
                  state_d = S_OFF;
                  tick_d  = OFF_LOAD;
               end else begin
                  state_d = S_GAP;
                  tick_d  = GAP_LOAD;
               end
            end else begin
               tick_d = tick_q - TICK_W'(1);
            end
         end

         S_OFF: begin
            if (tick_zero) begin
               state_d = S_ON;
               tick_d  = ON_LOAD;
               led_d   = 1'b1;
            end else begin
               tick_d = tick_q - TICK_W'(1);
            end
         end

         S_GAP: begin
            if (tick_zero) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               tick_d = tick_q - TICK_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            led_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         remaining_q <= '0;
         led_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         remaining_q <= remaining_d;
         led_q       <= led_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.led  = led_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_count_blinker.sv
// Randomised and directed checks of count_blinker against a frame-position
// model: outputs are derived from the cycle offset since the accepting edge.
module tb_count_blinker;

   localparam int WIDTH = 8;
   localparam int ON    = 2;
   localparam int OFF   = 3;
   localparam int GAP   = 4;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   count_blinker_if #(.WIDTH(WIDTH)) bif ();

   count_blinker #(
      .WIDTH     (WIDTH),
      .ON_TICKS  (ON),
      .OFF_TICKS (OFF),
      .GAP_TICKS (GAP),
      .TICK_W    (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Frame length in cycles from the accepting edge to the last busy cycle.
   function automatic int frame_len(input int n);
      return (n == 0) ? 0 : n * ON + (n - 1) * OFF + GAP;
   endfunction

   // Model: k = 1-based cycle index after the accepting edge of the current frame.
   int   m_k, m_n, m_len;
   bit   m_act;
   logic s_rst, s_start;
   int   s_val;
   logic e_led, e_busy, e_done;

   always begin
      @(posedge clk);
      s_rst   = rst;
      s_start = bif.start;
      s_val   = int'(bif.value);
      #1;
      if (s_rst !== 1'b1) begin
         m_act = 1'b0;
      end else if (!m_act || m_k == m_len + 1) begin
         if (s_start === 1'b1) begin
            m_act = 1'b1;
            m_n   = s_val;
            m_len = frame_len(s_val);
            m_k   = 1;
         end else begin
            m_act = 1'b0;
         end
      end else begin
         m_k++;
      end
      e_led  = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (m_act) begin
         e_busy = (m_k <= m_len);
         e_done = (m_k == m_len + 1);
         e_led  = (m_k - 1 < m_n * ON + (m_n - 1) * OFF) && (((m_k - 1) % (ON + OFF)) < ON);
      end
      check("model_led",  32'(bif.led),  32'(e_led));
      check("model_busy", 32'(bif.busy), 32'(e_busy));
      check("model_done", 32'(bif.done), 32'(e_done));
   end

   // Leaves the caller at the sample point of cycle 1 after the accepting edge.
   task automatic pulse_start(input int v);
      @(negedge clk);
      bif.start = 1'b1;
      bif.value = WIDTH'(v);
      @(posedge clk);
      #1;
      bif.start = 1'b0;
   endtask

   // Counts cycles (current sample = 1) until done, and led pulses seen on the way.
   task automatic wait_done(input int limit, output int n, output int pulses);
      logic prev;
      prev   = 1'b0;
      n      = 1;
      pulses = 0;
      forever begin
         if (bif.led === 1'b1 && prev !== 1'b1) pulses++;
         prev = bif.led;
         if (bif.done === 1'b1 || n >= limit) break;
         @(posedge clk);
         #1;
         n++;
      end
      if (bif.done !== 1'b1) check("done_timeout", 32'(n), 32'(limit + 1));
   endtask

   initial begin
      int n, p, busy_cnt;
      logic [15:0] seq;

      bif.start = 1'b0;
      bif.value = '0;
      rst       = 1'b1;
      #1 rst    = 1'b0;

      // Reset held with start high: outputs stay low.
      bif.start = 1'b1;
      bif.value = 8'd3;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("rst_led",  32'(bif.led),  0);
         check("rst_busy", 32'(bif.busy), 0);
         check("rst_done", 32'(bif.done), 0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      bif.start = 1'b0;
      check("rel_led",  32'(bif.led),  1);
      check("rel_busy", 32'(bif.busy), 1);
      wait_done(100, n, p);
      check("rel_latency", 32'(n), 17);
      repeat (3) @(posedge clk);

      // value=3: exact led sequence, busy span and done timing.
      pulse_start(3);
      busy_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         seq[15-i] = bif.led;
         if (bif.busy === 1'b1) busy_cnt++;
      end
      check("v3_led_seq", 32'(seq), 32'h0000_C630);
      check("v3_busy_cnt", 32'(busy_cnt), 16);
      @(posedge clk);
      #1;
      check("v3_done", 32'(bif.done), 1);
      check("v3_busy_end", 32'(bif.busy), 0);
      @(posedge clk);
      #1;
      check("v3_done_clr", 32'(bif.done), 0);

      // value=0: immediate done, no pulse, no busy.
      repeat (2) @(posedge clk);
      pulse_start(0);
      check("v0_done", 32'(bif.done), 1);
      check("v0_busy", 32'(bif.busy), 0);
      check("v0_led",  32'(bif.led),  0);
      @(posedge clk);
      #1;
      check("v0_done_clr", 32'(bif.done), 0);

      // value=2 with an ignored start(value=5) mid-frame.
      repeat (2) @(posedge clk);
      pulse_start(2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      bif.start = 1'b1;
      bif.value = 8'd5;
      @(posedge clk);
      #1;
      bif.start = 1'b0;
      wait_done(100, n, p);
      check("v2_latency", 32'(n), 8);
      busy_cnt = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bif.busy === 1'b1 || bif.led === 1'b1) busy_cnt++;
      end
      check("v2_no_refire", 32'(busy_cnt), 0);

      // value=1 with start held: done every 7 cycles.
      @(negedge clk);
      bif.start = 1'b1;
      bif.value = 8'd1;
      @(posedge clk);
      #1;
      wait_done(100, n, p);
      check("held_first", 32'(n), 7);
      for (int r = 0; r < 2; r++) begin
         @(posedge clk);
         #1;
         wait_done(100, n, p);
         check("held_period", 32'(n), 7);
         check("held_pulses", 32'(p), 1);
      end
      bif.start = 1'b0;
      repeat (3) @(posedge clk);

      // Full-width count.
      pulse_start(255);
      wait_done(2000, n, p);
      check("v255_latency", 32'(n), 1277);
      check("v255_pulses",  32'(p), 255);
      repeat (2) @(posedge clk);

      // Reset during pulse 2 of a value=4 frame.
      pulse_start(4);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      check("mid_pulse2_led", 32'(bif.led), 1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_led",  32'(bif.led),  0);
      check("mid_rst_busy", 32'(bif.busy), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      pulse_start(1);
      check("post_rst_led", 32'(bif.led), 1);
      wait_done(100, n, p);
      check("post_rst_latency", 32'(n), 7);

      // Randomised start/value traffic; the model checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         bif.start = ($urandom_range(0, 7) == 0);
         bif.value = WIDTH'($urandom_range(0, 5));
      end
      @(negedge clk);
      bif.start = 1'b0;
      repeat (40) @(posedge clk);
      #2;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
